// File: rtl/sv32_walker.sv
// rtl/sv32_walker.sv - Sv32 translation responder with two-level page-table walk
// Optional micro-TLB is built when SV32_WALKER_TLB_EN is defined.
module sv32_walker #(
  parameter int TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmu_vaddr_i,
  input  logic        mmu_req_valid_i,
  input  logic        mmu_is_store_i,
  input  logic        mmu_is_inst_i,
  input  logic [1:0]  mmu_priv_i,
  input  logic        mmu_enable_i,
  input  logic [21:0] mmu_satp_ppn_i,
  input  logic [8:0]  mmu_satp_asid_i,
  input  logic        mmu_mxr_i,
  input  logic        mmu_sum_i,
  output logic [31:0] mmu_paddr_o,
  output logic        mmu_resp_valid_o,
  output logic        mmu_page_fault_o,
  output logic        mmu_mem_req_o,
  output logic [31:0] mmu_mem_addr_o,
  input  logic [31:0] mmu_mem_rdata_i,
  input  logic        mmu_mem_rvalid_i,
  input  logic        mmu_flush_i
);
  localparam logic [1:0] IDLE = 2'd0, L1 = 2'd1, L0 = 2'd2, DONE = 2'd3;

  logic [1:0]  state;
  logic [31:0] vaddr_q, paddr_q, mem_addr_q;
  logic        is_store_q, is_inst_q, mxr_q, sum_q, fault_q, mem_req_q;
  logic [1:0]  priv_q;

  // Priv 0 is U; anything else reaching here is treated as S (M is bypassed).
  function automatic logic perm_ok(input logic r, input logic w, input logic x, input logic u,
                                   input logic a, input logic d, input logic st, input logic inst,
                                   input logic [1:0] priv, input logic mxr, input logic sum);
    logic ok;
    if (inst) ok = x;
    else if (st) ok = w;
    else ok = r | (x & mxr);
    if (priv == 2'd0) ok = ok & u;
    else if (u) ok = ok & ~inst & sum;
    return ok & a & (~st | d);
  endfunction

  logic        bypass;
  logic [31:0] pte;
  logic [19:0] pte_ppn;
  logic        pte_bad, pte_leaf, is_super, leaf_fault;
  logic [31:0] leaf_paddr;
  logic        tlb_hit, hit_fault;
  logic [31:0] hit_paddr;

  assign bypass     = ~mmu_enable_i | (mmu_priv_i == 2'd3);
  assign pte        = mmu_mem_rdata_i;
  assign pte_ppn    = pte[29:10];
  assign pte_bad    = ~pte[0] | (~pte[1] & pte[2]);
  assign pte_leaf   = pte[1] | pte[3];
  assign is_super   = (state == L1);
  assign leaf_fault = (is_super & (pte_ppn[9:0] != 10'd0)) |
                      ~perm_ok(pte[1], pte[2], pte[3], pte[4], pte[6], pte[7],
                               is_store_q, is_inst_q, priv_q, mxr_q, sum_q);
  assign leaf_paddr = is_super ? {pte_ppn[19:10], vaddr_q[21:0]} : {pte_ppn, vaddr_q[11:0]};

`ifdef SV32_WALKER_TLB_EN
  localparam int IW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  logic [TLB_ENTRIES-1:0] tlb_valid;
  logic [19:0]            tlb_vpn   [TLB_ENTRIES];
  logic [8:0]             tlb_asid  [TLB_ENTRIES];
  logic                   tlb_super [TLB_ENTRIES];
  logic [19:0]            tlb_ppn   [TLB_ENTRIES];
  logic [4:0]             tlb_perm  [TLB_ENTRIES];  // {d, x, w, r, u}
  logic [IW-1:0]          rr_ptr;
  logic                   any_hit, h_super, fill;
  logic [19:0]            h_ppn;
  logic [4:0]             h_perm;

  always_comb begin
    any_hit = 1'b0;
    h_super = 1'b0;
    h_ppn   = '0;
    h_perm  = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!any_hit && tlb_valid[i] && tlb_asid[i] == mmu_satp_asid_i &&
          tlb_vpn[i][19:10] == mmu_vaddr_i[31:22] &&
          (tlb_super[i] || tlb_vpn[i][9:0] == mmu_vaddr_i[21:12])) begin
        any_hit = 1'b1;
        h_super = tlb_super[i];
        h_ppn   = tlb_ppn[i];
        h_perm  = tlb_perm[i];
      end
    end
  end

  assign tlb_hit   = any_hit & (state == IDLE) & mmu_req_valid_i & ~bypass & ~mmu_flush_i & ~rst;
  assign hit_fault = ~perm_ok(h_perm[1], h_perm[2], h_perm[3], h_perm[0], 1'b1, h_perm[4],
                              mmu_is_store_i, mmu_is_inst_i, mmu_priv_i, mmu_mxr_i, mmu_sum_i);
  assign hit_paddr = h_super ? {h_ppn[19:10], mmu_vaddr_i[21:0]} : {h_ppn, mmu_vaddr_i[11:0]};
  assign fill      = (state == L1 || state == L0) && mem_req_q && mmu_mem_rvalid_i &&
                     !pte_bad && pte_leaf && !leaf_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      tlb_valid <= '0;
      rr_ptr    <= '0;
    end else if (mmu_flush_i) begin
      tlb_valid <= '0;
    end else if (fill) begin
      tlb_valid[rr_ptr] <= 1'b1;
      tlb_vpn[rr_ptr]   <= vaddr_q[31:12];
      tlb_asid[rr_ptr]  <= mmu_satp_asid_i;
      tlb_super[rr_ptr] <= is_super;
      tlb_ppn[rr_ptr]   <= pte_ppn;
      tlb_perm[rr_ptr]  <= {pte[7], pte[3], pte[2], pte[1], pte[4]};
      rr_ptr            <= (rr_ptr == IW'(TLB_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end
`else
  localparam int unused_tlb_entries = TLB_ENTRIES;
  logic unused_asid;
  assign unused_asid = ^mmu_satp_asid_i;
  assign tlb_hit   = 1'b0;
  assign hit_fault = 1'b0;
  assign hit_paddr = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{mmu_satp_ppn_i[21:20], pte[31:30], pte[9:8], pte[5], vaddr_q[31:22]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      vaddr_q    <= '0;
      paddr_q    <= '0;
      fault_q    <= 1'b0;
      is_store_q <= 1'b0;
      is_inst_q  <= 1'b0;
      priv_q     <= 2'd0;
      mxr_q      <= 1'b0;
      sum_q      <= 1'b0;
    end else if (mmu_flush_i) begin
      state     <= IDLE;
      mem_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mmu_req_valid_i && !bypass && !tlb_hit) begin
          state      <= L1;
          vaddr_q    <= mmu_vaddr_i;
          is_store_q <= mmu_is_store_i;
          is_inst_q  <= mmu_is_inst_i;
          priv_q     <= mmu_priv_i;
          mxr_q      <= mmu_mxr_i;
          sum_q      <= mmu_sum_i;
          mem_addr_q <= {mmu_satp_ppn_i[19:0], 12'b0} + {20'b0, mmu_vaddr_i[31:22], 2'b00};
        end
        L1, L0: begin
          // The request is raised one cycle after entering a level; rvalid only counts while it is up.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mmu_mem_rvalid_i) begin
            mem_req_q <= 1'b0;
            if (pte_bad || (!pte_leaf && state == L0)) begin
              fault_q <= 1'b1;
              paddr_q <= '0;
              state   <= DONE;
            end else if (!pte_leaf) begin
              state      <= L0;
              mem_addr_q <= {pte_ppn, 12'b0} + {20'b0, vaddr_q[21:12], 2'b00};
            end else begin
              fault_q <= leaf_fault;
              paddr_q <= leaf_fault ? 32'd0 : leaf_paddr;
              state   <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mmu_resp_valid_o = 1'b0;
    mmu_page_fault_o = 1'b0;
    mmu_paddr_o      = '0;
    if (state == DONE) begin
      mmu_resp_valid_o = 1'b1;
      mmu_page_fault_o = fault_q;
      mmu_paddr_o      = paddr_q;
    end else if (state == IDLE && !rst && mmu_req_valid_i) begin
      if (bypass) begin
        mmu_resp_valid_o = 1'b1;
        mmu_paddr_o      = mmu_vaddr_i;
      end else if (tlb_hit) begin
        mmu_resp_valid_o = 1'b1;
        mmu_page_fault_o = hit_fault;
        mmu_paddr_o      = hit_fault ? 32'd0 : hit_paddr;
      end
    end
  end

  assign mmu_mem_req_o  = mem_req_q;
  assign mmu_mem_addr_o = mem_addr_q;
endmodule

// File: tb/tb_sv32_walker.sv
// tb/tb_sv32_walker.sv - scoreboard bench for sv32_walker (TLB cases need SV32_WALKER_TLB_EN)
module tb_sv32_walker;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] vaddr;
  logic        req_valid, is_store, is_inst, enable, mxr, sum, flush;
  logic [1:0]  priv;
  logic [21:0] satp_ppn;
  logic [8:0]  satp_asid;
  logic [31:0] resp_paddr, mem_addr, mem_rdata;
  logic        resp_valid, resp_fault, mem_req, mem_rvalid;

  sv32_walker dut (
    .clk(clk), .rst(rst),
    .mmu_vaddr_i(vaddr), .mmu_req_valid_i(req_valid), .mmu_is_store_i(is_store),
    .mmu_is_inst_i(is_inst), .mmu_priv_i(priv), .mmu_enable_i(enable),
    .mmu_satp_ppn_i(satp_ppn), .mmu_satp_asid_i(satp_asid),
    .mmu_mxr_i(mxr), .mmu_sum_i(sum),
    .mmu_paddr_o(resp_paddr), .mmu_resp_valid_o(resp_valid), .mmu_page_fault_o(resp_fault),
    .mmu_mem_req_o(mem_req), .mmu_mem_addr_o(mem_addr),
    .mmu_mem_rdata_i(mem_rdata), .mmu_mem_rvalid_i(mem_rvalid),
    .mmu_flush_i(flush)
  );

  typedef struct { logic fault; logic [31:0] paddr; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int lat; } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, req_cyc = 0, mem_reqs = 0;
  bit   auto_mem = 1'b1;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got paddr %h fault %b with nothing expected", resp_paddr, resp_fault);
        end else begin
          e = exp_q.pop_front();
          check("resp_fault", 32'(resp_fault), 32'(e.fault));
          check("resp_paddr", resp_paddr, e.paddr);
          if (e.lat >= 0) check("resp_latency", 32'(cyc - req_cyc), 32'(e.lat));
        end
      end
    end
  end

  // PTE memory model
  initial begin : memory
    mem_t m;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_req) begin
        mem_reqs++;
        if (mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mem_req: got addr %h expected no request", mem_addr);
          m.data = 32'd0;
          m.lat  = 0;
        end else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
        end
        repeat (m.lat) @(negedge clk);
        mem_rdata  = m.data;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic mem_push(input logic [31:0] a, input logic [31:0] d, input int lat);
    mem_t m;
    m.addr = a; m.data = d; m.lat = lat;
    mem_q.push_back(m);
  endtask

  task automatic do_req(input logic [31:0] va, input logic st, input logic inst, input logic [1:0] pv,
                        input logic mx, input logic sm, input logic ef, input logic [31:0] ep,
                        input int lat, input int nreads, input logic fl);
    exp_t e;
    int   m0;
    bit   got;
    e.fault = ef; e.paddr = ep; e.lat = lat;
    exp_q.push_back(e);
    m0 = mem_reqs;
    got = 1'b0;
    @(posedge clk); #1;
    vaddr = va; is_store = st; is_inst = inst; priv = pv; mxr = mx; sum = sm;
    req_valid = 1'b1;
    req_cyc = cyc;
    if (fl) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; break; end
    end
    check("resp_seen", 32'(got), 32'd1);
    if (!got) exp_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mem_reads", 32'(mem_reqs - m0), 32'(nreads));
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic wait_mem(input string nm, input logic [31:0] a);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check(nm, mem_req ? mem_addr : 32'hDEAD_BEEF, a);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1; vaddr = '0; req_valid = 1'b0; is_store = 1'b0; is_inst = 1'b0;
    priv = 2'd1; enable = 1'b1; satp_ppn = 22'h80000; satp_asid = 9'd1;
    mxr = 1'b0; sum = 1'b0; flush = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_paddr", resp_paddr, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Bypass: MMU off, then M mode
    enable = 1'b0;
    do_req(32'h3000_0010, 0, 0, 2'd1, 0, 0, 0, 32'h3000_0010, 0, 0, 0);
    enable = 1'b1;
    do_req(32'h1234_5678, 1, 0, 2'd3, 0, 0, 0, 32'h1234_5678, 0, 0, 0);

    // Two-level walk
    mem_push(32'h8000_0004, 32'h2000_0401, 2);
    mem_push(32'h8000_1004, 32'h2004_8C4B, 1);
    do_req(32'h0040_1234, 0, 1, 2'd1, 0, 0, 0, 32'h8012_3234, -1, 2, 0);
`ifdef SV32_WALKER_TLB_EN
    do_req(32'h0040_1FF0, 0, 1, 2'd1, 0, 0, 0, 32'h8012_3FF0, 0, 0, 0);
`endif

    // Superpage, then misaligned superpage
    mem_push(32'h8000_0804, 32'h2010_004B, 1);
    do_req(32'h8040_0010, 0, 1, 2'd1, 0, 0, 0, 32'h8040_0010, -1, 1, 0);
    mem_push(32'h8000_0808, 32'h2010_044B, 0);
    do_req(32'h8080_0010, 0, 1, 2'd1, 0, 0, 1, 32'h0, -1, 1, 0);

    // V = 0
    mem_push(32'h8000_000C, 32'h0, 1);
    do_req(32'h00C0_0000, 0, 0, 2'd1, 0, 0, 1, 32'h0, -1, 1, 0);

    // Store: D = 0 faults, D = 1 passes
    mem_push(32'h8000_0010, 32'h2000_0801, 0);
    mem_push(32'h8000_2008, 32'h2005_0047, 0);
    do_req(32'h0100_2010, 1, 0, 2'd1, 0, 0, 1, 32'h0, -1, 2, 0);
    mem_push(32'h8000_0010, 32'h2000_0801, 0);
    mem_push(32'h8000_2008, 32'h2005_00C7, 0);
    do_req(32'h0100_2010, 1, 0, 2'd1, 0, 0, 0, 32'h8014_0010, -1, 2, 0);

    // U page: S-mode fetch faults, U-mode fetch passes
    mem_push(32'h8000_0014, 32'h2000_0C01, 0);
    mem_push(32'h8000_300C, 32'h2006_0059, 1);
    do_req(32'h0140_3000, 0, 1, 2'd1, 0, 1, 1, 32'h0, -1, 2, 0);
    mem_push(32'h8000_0014, 32'h2000_0C01, 0);
    mem_push(32'h8000_300C, 32'h2006_0059, 1);
    do_req(32'h0140_3000, 0, 1, 2'd0, 0, 0, 0, 32'h8018_0000, -1, 2, 0);

    // X-only page load: MXR = 0 faults, MXR = 1 passes
    mem_push(32'h8000_0018, 32'h2000_1001, 0);
    mem_push(32'h8000_4010, 32'h2007_0049, 0);
    do_req(32'h0180_4008, 0, 0, 2'd1, 0, 0, 1, 32'h0, -1, 2, 0);
    mem_push(32'h8000_0018, 32'h2000_1001, 0);
    mem_push(32'h8000_4010, 32'h2007_0049, 0);
    do_req(32'h0180_4008, 0, 0, 2'd1, 1, 0, 0, 32'h801C_0008, -1, 2, 0);

    // Flush during L0 wait, then a late rvalid
    flush_pulse();
    auto_mem = 1'b0;
    @(posedge clk); #1;
    vaddr = 32'h0040_1234; is_store = 1'b0; is_inst = 1'b1; priv = 2'd1; mxr = 1'b0; sum = 1'b0;
    req_valid = 1'b1;
    wait_mem("flush_l1_addr", 32'h8000_0004);
    mem_rdata = 32'h2000_0401; mem_rvalid = 1'b1;
    @(negedge clk); mem_rvalid = 1'b0;
    wait_mem("flush_l0_addr", 32'h8000_1004);
    @(posedge clk); #1; flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_drops_req", 32'(mem_req), 32'd0);
    mem_rdata = 32'h2004_8C4B; mem_rvalid = 1'b1;
    @(negedge clk); mem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_req_low", 32'(mem_req), 32'd0);
    check("flush_no_resp", 32'(exp_q.size()), 32'd0);
    auto_mem = 1'b1;
    mem_push(32'h8000_0004, 32'h2000_0401, 0);
    mem_push(32'h8000_1004, 32'h2004_8C4B, 0);
    do_req(32'h0040_1234, 0, 1, 2'd1, 0, 0, 0, 32'h8012_3234, -1, 2, 0);

`ifdef SV32_WALKER_TLB_EN
    // Five superpages into a four-entry TLB: the first fill is evicted
    flush_pulse();
    for (int k = 1; k <= 5; k++) begin
      mem_push(32'h8000_0000 + ((32'h100 + k) << 2), ((32'h300 + k) << 20) | 32'hCF, 1);
      do_req((32'h100 + k) << 22 | 32'h44, 0, 0, 2'd1, 0, 0, 0, ((32'h300 + k) << 22) | 32'h44, -1, 1, 0);
    end
    do_req((32'h105 << 22) | 32'h8, 0, 0, 2'd1, 0, 0, 0, (32'h305 << 22) | 32'h8, 0, 0, 0);
    do_req((32'h102 << 22) | 32'h8, 0, 0, 2'd0, 0, 0, 1, 32'h0, 0, 0, 0);
    mem_push(32'h8000_0404, (32'h301 << 20) | 32'hCF, 0);
    do_req((32'h101 << 22) | 32'hC, 0, 0, 2'd1, 0, 0, 0, (32'h301 << 22) | 32'hC, -1, 1, 0);
    // Flush alongside a would-be hit: hit suppressed, lookup walks afresh
    mem_push(32'h8000_040C, (32'h303 << 20) | 32'hCF, 0);
    do_req((32'h103 << 22) | 32'h10, 0, 0, 2'd1, 0, 0, 0, (32'h303 << 22) | 32'h10, -1, 1, 1);
`endif

    repeat (5) @(negedge clk);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("mem_drained", 32'(mem_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sv32_walker.md
# sv32_walker

Sv32 translation responder that serves the `mmu_*` request/response protocol driven by the fetch and load/store units. It accepts a virtual address and returns a physical address or a page fault. On a miss it walks the two-level Sv32 page table through a single-outstanding memory read port and applies the R/W/X/U/A/D, MXR and SUM permission rules. It sits between a requester (IFU or LSU) and the memory arbiter; one instance serves each requester.

## Interface
- `TLB_ENTRIES`, default 4: entries in the optional micro-TLB. Must be a power of 2; only used with `SV32_WALKER_TLB_EN`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `mmu_vaddr_i` in 32: virtual address. Held stable from request until response.
- `mmu_req_valid_i` in 1: request valid. Level signal; may stay high continuously.
- `mmu_is_store_i` in 1: store access (needs W).
- `mmu_is_inst_i` in 1: instruction fetch (needs X).
- `mmu_priv_i` in 2: effective privilege (0 = U, 1 = S, 3 = M).
- `mmu_enable_i` in 1: satp.MODE = Sv32.
- `mmu_satp_ppn_i` in 22: root page table PPN.
- `mmu_satp_asid_i` in 9: current ASID.
- `mmu_mxr_i`, `mmu_sum_i` in 1 each: mstatus.MXR and mstatus.SUM.
- `mmu_paddr_o` out 32: translated address, valid when `mmu_resp_valid_o` = 1.
- `mmu_resp_valid_o` out 1: response strobe, one cycle per completed walk.
- `mmu_page_fault_o` out 1: qualifies the response as a page fault.
- `mmu_mem_req_o` out 1: PTE read request, held high until `mmu_mem_rvalid_i`.
- `mmu_mem_addr_o` out 32: PTE address, word aligned.
- `mmu_mem_rdata_i` in 32: PTE data.
- `mmu_mem_rvalid_i` in 1: PTE data valid, one-cycle pulse.
- `mmu_flush_i` in 1: sfence.vma / satp write. Aborts any walk and invalidates the TLB.

## Operation
- **Bypass.** When `mmu_enable_i` = 0 or `mmu_priv_i` = 3:
  - `mmu_paddr_o` = `mmu_vaddr_i`.
  - `mmu_resp_valid_o` = `mmu_req_valid_i`, combinationally.
  - No fault.
  - No memory traffic.
- **FSM states:** IDLE, L1, L0, DONE.
  - IDLE -> L1 when a translation is needed and there is no bypass and no TLB hit.
  - L1: address is `{satp_ppn[19:0], 12'b0} + {vpn1, 2'b00}`.
  - L0: address is `{pte.ppn[19:0], 12'b0} + {vpn0, 2'b00}`.
  - Physical addresses are truncated to 32 bits; PTE ppn[21:20] are ignored.
- **PTE evaluation on `mmu_mem_rvalid_i`:**
  - Fault if V = 0, or R = 0 and W = 1.
  - Non-leaf (R = X = 0): in L1, go to L0; in L0, fault.
  - Leaf in L1 is a superpage. Fault if ppn[9:0] != 0. Otherwise paddr = `{ppn[19:10], vaddr[21:0]}`.
  - Leaf in L0: paddr = `{ppn[19:0], vaddr[11:0]}`.
- **Permission rules (any failure is a fault):**
  - Instruction fetch needs X.
  - Store needs W.
  - Load needs R, or X with MXR = 1.
  - In U mode the page needs U = 1.
  - In S mode a page with U = 1 faults for fetches always, and for data unless SUM = 1.
  - A = 0 faults.
  - A store with D = 0 faults. There is no hardware A/D update.
- **DONE:** drive the registered paddr/fault with `mmu_resp_valid_o` = 1 for one cycle, then return to IDLE. If `mmu_req_valid_i` is still high, a new lookup starts the following cycle.
- **Fault response:** `mmu_paddr_o` = 0.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, all TLB entries invalid, replacement pointer 0.
- **Latency:**
  - Bypass: 0 cycles.
  - TLB hit: 0 cycles, combinational from IDLE.
  - Walk: 1 cycle to assert the L1 request, plus memory latency per level, plus 1 cycle in DONE.
- **`mmu_mem_req_o` handshake:** rises the cycle after entering L1/L0. Address is stable while high. Drops the cycle after `mmu_mem_rvalid_i`.
- **`mmu_flush_i`:** highest priority.
  - FSM goes to IDLE, `mmu_mem_req_o` drops next cycle.
  - No response is issued for the aborted walk.
  - `mmu_mem_rvalid_i` arriving in IDLE is ignored.
- **Flush and hit in the same cycle:** the hit is suppressed and the request is re-looked-up after the flush.
- **Reset mid-walk:** same as flush; any late `rvalid` is ignored.
- **Request changes:** `mmu_vaddr_i` and attributes are sampled only on IDLE -> L1. Requester changes during a walk are not tracked.

## Configuration
- **`SV32_WALKER_TLB_EN` defined:**
  - `TLB_ENTRIES`-entry fully associative TLB.
  - Tag: vpn[19:0], ASID, superpage bit. Superpage entries match on vpn1 only.
  - Each entry stores ppn and U/R/W/X/D.
  - The permission rules above are re-evaluated on every hit; a hit that fails them faults with no walk.
  - Fill only on a successful walk, round-robin replacement.
  - Faults are not cached.
- **`SV32_WALKER_TLB_EN` undefined:** no TLB storage; every non-bypass request walks.

## Test plan
- **Bypass:** `mmu_enable_i` = 0, vaddr 0x3000_0010 -> paddr 0x3000_0010 the same cycle, `mmu_mem_req_o` never asserts.
- **Two-level walk:** satp_ppn 0x80000, S mode, fetch vaddr 0x0040_1234.
  - L1 read at 0x8000_0004 returns 0x2000_0401.
  - L0 read at 0x8000_1004 returns 0x2004_8C4B.
  - Response paddr 0x8012_3234, no fault.
- **Superpage:** fetch vaddr 0x8040_0010, L1 read at 0x8000_0804 returns 0x2010_004B -> paddr 0x8040_0010. Repeat with ppn0 = 1 -> fault.
- **Faults:**
  - V = 0 -> fault.
  - Store to a page with D = 0 -> fault.
  - S-mode fetch from a U = 1 page -> fault.
  - Load from an X-only page faults with MXR = 0 and passes with MXR = 1.
- **TLB (`SV32_WALKER_TLB_EN`):** repeat the two-level case -> second request responds in 0 cycles with no memory traffic. Fill 5 distinct pages -> the first-filled entry is evicted and walks again.
- **Flush mid-walk:** pulse `mmu_flush_i` during L0 wait, then deliver `rvalid` -> no response, FSM in IDLE, and the next request walks from L1.
